// File: rtl/time_slot_executor.sv
// rtl/time_slot_executor.sv - 4-deep duration FIFO feeding an IDLE/RUN/DONE slot countdown.
// Optional sticky drop flag compiled in with EXEC_OVERFLOW_EN.
module time_slot_executor (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       abort,
  output logic       busy,
  output logic [7:0] remaining,
  output logic       done,
  output logic [2:0] fifo_count,
  output logic [7:0] completed
`ifdef EXEC_OVERFLOW_EN
  ,
  output logic       overflow
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       push;
  logic       pop;
  logic [7:0] remaining_next;
  logic [7:0] completed_next;

  // Ready comes from the registered count only, so a full FIFO drops the word even if it pops this edge.
  assign data_ready = (fifo_count < 3'd4);
  assign push       = data_valid && data_ready;

  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    remaining_next = remaining;
    completed_next = completed;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != 3'd0) begin
          pop            = 1'b1;
          remaining_next = mem[rd_ptr];
          if (mem[rd_ptr] != 8'd0) begin
            state_next = RUN;
          end else begin
            state_next     = DONE;
            completed_next = completed + 8'd1;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_next     = IDLE;
          remaining_next = 8'd0;
        end else begin
          remaining_next = remaining - 8'd1;
          if (remaining == 8'd1) begin
            state_next     = DONE;
            completed_next = completed + 8'd1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next     = IDLE;
        remaining_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= 8'd0;
      completed <= 8'd0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      completed <= completed_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 8'd0;
      end
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef EXEC_OVERFLOW_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (data_valid && !data_ready) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_time_slot_executor.sv
// tb/tb_time_slot_executor.sv - scoreboard bench for time_slot_executor.
// Stimulus queues expected slot starts and done pulses; a negedge monitor consumes them.
module tb_time_slot_executor;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       abort;
  logic       busy;
  logic [7:0] remaining;
  logic       done;
  logic [2:0] fifo_count;
  logic [7:0] completed;
`ifdef EXEC_OVERFLOW_EN
  logic       overflow;
`endif

  int tests = 0;
  int fails = 0;

  int start_q[$];
  int done_len_q[$];
  int done_cnt_q[$];

  time_slot_executor dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .abort      (abort),
    .busy       (busy),
    .remaining  (remaining),
    .done       (done),
    .fifo_count (fifo_count),
    .completed  (completed)
`ifdef EXEC_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    int n = 0;
    while (!data_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", data_ready, 1);
    data_in    = v;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || done || fifo_count != 3'd0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", int'(busy || done || fifo_count != 3'd0), 0);
  endtask

  task automatic wait_rem(input int v);
    int n = 0;
    while (int'(remaining) != v && n < 50) begin
      tick();
      n++;
    end
    chk("reach_remaining", remaining, v);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_remaining"}, remaining, 0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_completed"}, completed, 0);
    chk({tag, "_data_ready"}, data_ready, 1);
`ifdef EXEC_OVERFLOW_EN
    chk({tag, "_overflow"}, overflow, 0);
`endif
  endtask

  // Monitor: slot starts, per-cycle countdown, done pulses against the queues.
  int prev_busy = 0;
  int prev_rem  = 0;
  int busy_len  = 0;
  always @(negedge clock) begin
    if (reset) begin
      prev_busy = 0;
      prev_rem  = 0;
      busy_len  = 0;
    end else begin
      chk("busy_done_exclusive", int'(busy && done), 0);
      if (busy && prev_busy == 0) begin
        if (start_q.size() == 0) begin
          chk("unexpected_slot_start", remaining, -1);
        end else begin
          chk("slot_start_value", remaining, start_q.pop_front());
        end
        busy_len = 1;
      end else if (busy) begin
        chk("remaining_decrement", remaining, prev_rem - 1);
        busy_len++;
      end else begin
        chk("remaining_zero_outside_run", remaining, 0);
      end
      if (done) begin
        if (done_len_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("slot_busy_cycles", (prev_busy != 0) ? busy_len : 0, done_len_q.pop_front());
          chk("completed_at_done", completed, done_cnt_q.pop_front());
        end
      end
      prev_busy = int'(busy);
      prev_rem  = int'(remaining);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    data_in    = 8'd0;
    data_valid = 1'b0;
    abort      = 1'b0;
    #2;
    check_reset_values("reset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single 3-cycle slot.
    start_q.push_back(3);
    done_len_q.push_back(3);
    done_cnt_q.push_back(1);
    push(8'h03);
    chk("t3_fifo_after_push", fifo_count, 1);
    chk("t3_busy_after_push", busy, 0);
    tick();
    chk("t3_busy_latency", busy, 1);
    chk("t3_remaining_first", remaining, 3);
    wait_idle(100);
    chk("t3_completed", completed, 1);

    // Zero-length slot: no busy, immediate done.
    done_len_q.push_back(0);
    done_cnt_q.push_back(2);
    push(8'h00);
    chk("t0_busy_after_push", busy, 0);
    tick();
    chk("t0_done_pulse", done, 1);
    chk("t0_busy", busy, 0);
    chk("t0_completed", completed, 2);
    tick();
    chk("t0_done_one_cycle", done, 0);
    wait_idle(100);

    // Fill behind a long slot, drop one word, then drain everything with abort held.
    start_q.push_back(8'h20);
    push(8'h20);
    tick();
    chk("fill_long_slot_busy", busy, 1);
    start_q.push_back(8'hF2);
    push(8'hF2);
    chk("fill_count1", fifo_count, 1);
    start_q.push_back(8'h02);
    push(8'h02);
    chk("fill_count2", fifo_count, 2);
    start_q.push_back(8'h01);
    push(8'h01);
    chk("fill_count3", fifo_count, 3);
    start_q.push_back(8'h01);
    push(8'h01);
    chk("fill_count4", fifo_count, 4);
    chk("fill_ready_low", data_ready, 0);
    data_in    = 8'h05;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("full_drop_count", fifo_count, 4);
`ifdef EXEC_OVERFLOW_EN
    chk("overflow_set", overflow, 1);
`endif
    abort = 1'b1;
    repeat (10) tick();
    abort = 1'b0;
    chk("drain_fifo_empty", fifo_count, 0);
    chk("drain_busy", busy, 0);
    chk("drain_completed_unchanged", completed, 2);
`ifdef EXEC_OVERFLOW_EN
    chk("overflow_sticky", overflow, 1);
`endif

    // Abort mid-slot, next queued word starts.
    start_q.push_back(8'h0A);
    start_q.push_back(3);
    done_len_q.push_back(3);
    done_cnt_q.push_back(3);
    push(8'h0A);
    push(8'h03);
    wait_rem(6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_remaining", remaining, 0);
    chk("abort_no_done", done, 0);
    chk("abort_completed", completed, 2);
    tick();
    chk("abort_next_busy", busy, 1);
    chk("abort_next_remaining", remaining, 3);
    wait_idle(100);
    chk("abort_then_completed", completed, 3);

    // Asynchronous reset mid-slot with two words queued.
    start_q.push_back(8);
    push(8'h08);
    push(8'h02);
    push(8'h02);
    wait_rem(5);
    chk("prereset_fifo_count", fifo_count, 2);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_completed", completed, 0);
    chk("post_reset_fifo", fifo_count, 0);

    // 256 zero slots: completed walks to 255 then wraps to 0.
    for (int i = 1; i <= 256; i++) begin
      done_len_q.push_back(0);
      done_cnt_q.push_back(i % 256);
      push(8'h00);
    end
    wait_idle(100);
    chk("completed_wrap", completed, 0);

    repeat (3) tick();
    chk("start_queue_empty", start_q.size(), 0);
    chk("done_queue_empty", done_len_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
